// File: rtl/alu_seq_ctrl_if.sv
// Request and result channels between the ALU sequencer and its neighbours.
// slave = the sequencer itself; master = upstream issue / downstream consumer.
interface alu_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic [3:0]  in_func;
    logic [3:0]  in_inner;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;

    modport slave (
        input  in_valid, in_src1, in_src2, in_func, in_inner, out_ready,
        output in_ready, out_valid, out_result
    );

    modport master (
        output in_valid, in_src1, in_src2, in_func, in_inner, out_ready,
        input  in_ready, out_valid, out_result
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// ALU issue sequencer: holds operands for the selected path's latency, captures and hands off the result.
// Latency: result valid lat+1 cycles after accept (lat = MUL_LAT, DIV_LAT or 1); optional ALU_DIV_ZERO_FAST_EN.
// Backpressure: result held in DONE until out_ready; new op accepted only when idle or as the result drains.
module alu_seq_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    alu_seq_ctrl_if.slave      bus,
    output logic [63:0]        alu_src1,
    output logic [63:0]        alu_src2,
    output logic [3:0]         alu_func,
    output logic [3:0]         alu_inner,
    input  logic [63:0]        alu_result,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [63:0] src1;
        logic [63:0] src2;
        logic [3:0]  func;
        logic [3:0]  inner;
    } op_t;

    localparam logic [CNT_W-1:0] MUL_M1 = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_ld;
    op_t              op_q;
    logic [63:0]      res_q;
    logic             accept;
    logic             load;
    logic             capture;

    assign bus.in_ready = !rst && !flush &&
                          ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;

    // Counter preload is lat-1 so a single-cycle op spends exactly one cycle in EXEC.
    always_comb begin
        lat_ld = '0;
        if (bus.in_func == 4'd5) begin
            lat_ld = MUL_M1;
        end else if (bus.in_func == 4'd3) begin
`ifdef ALU_DIV_ZERO_FAST_EN
            lat_ld = (bus.in_src2 == 64'd0) ? '0 : DIV_M1;
`else
            lat_ld = DIV_M1;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        capture = 1'b0;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = EXEC;
                        cnt_d   = lat_ld;
                        load    = 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d = DONE;
                        capture = 1'b1;
                    end
                end
                DONE: begin
                    if (accept) begin
                        state_d = EXEC;
                        cnt_d   = lat_ld;
                        load    = 1'b1;
                    end else if (bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                op_q <= '{src1: bus.in_src1, src2: bus.in_src2,
                          func: bus.in_func, inner: bus.in_inner};
            end
            if (capture) begin
                res_q <= alu_result;
            end
        end
    end

    assign alu_src1       = op_q.src1;
    assign alu_src2       = op_q.src2;
    assign alu_func       = op_q.func;
    assign alu_inner      = op_q.inner;
    assign bus.out_result = res_q;
    assign bus.out_valid  = (state_q == DONE);
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Random + directed bench for alu_seq_ctrl: a stand-in ALU, a transaction-level reference
// model and a scoreboard that checks timing, handshakes and results every cycle.
module tb_alu_seq_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [63:0] alu_src1, alu_src2, alu_result;
    logic [3:0]  alu_func, alu_inner;
    logic        busy;
    logic        rand_rdy = 1'b0;
    logic        rdy_rnd  = 1'b1;
    logic        rdy_dir;
    bit          rst_prev = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    alu_seq_ctrl_if bus ();

    alu_seq_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_func   (alu_func),
        .alu_inner  (alu_inner),
        .alu_result (alu_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] alu_fn(input logic [3:0] f, input logic [3:0] inn,
                                           input logic [63:0] a, input logic [63:0] b);
        case (f)
            4'd0:    return (inn == 4'd1) ? a - b : a + b;
            4'd1:    return a << b[5:0];
            4'd2:    return {63'd0, $signed(a) < $signed(b)};
            4'd3:    return (b == 64'd0) ? {64{1'b1}} : a / b;
            4'd4:    return (inn == 4'd0) ? (a & b) : (inn == 4'd1) ? (a | b) : (a ^ b);
            4'd5:    return a * b;
            4'd6:    return a + b;
            4'd7:    return b;
            default: return a ^ b ^ {60'd0, inn};
        endcase
    endfunction

    assign alu_result    = alu_fn(alu_func, alu_inner, alu_src1, alu_src2);
    assign bus.out_ready = rand_rdy ? rdy_rnd : rdy_dir;

    function automatic int exp_lat(input logic [3:0] f, input logic [63:0] b);
        if (f == 4'd5) return MUL_LAT;
        if (f == 4'd3) begin
`ifdef ALU_DIV_ZERO_FAST_EN
            if (b == 64'd0) return 1;
`endif
            return DIV_LAT;
        end
        return 1;
    endfunction

    typedef struct {
        logic [63:0] s1, s2, res;
        logic [3:0]  f, inn;
        int          acc, due;
    } item_t;

    item_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= rst;
        if (rand_rdy) rdy_rnd <= ($urandom_range(0, 3) != 0);
    end

    // Scoreboard: reference transaction queue, checked every falling edge.
    always @(negedge clk) begin
        logic  ov_exp, ir_exp;
        item_t it;
        if (rst_prev) begin
            chk("rst_out_result", bus.out_result, 64'd0);
            chk("rst_alu_src1", alu_src1, 64'd0);
            chk("rst_alu_src2", alu_src2, 64'd0);
            chk("rst_alu_func", {60'd0, alu_func}, 64'd0);
            chk("rst_alu_inner", {60'd0, alu_inner}, 64'd0);
        end
        ov_exp = (q.size() != 0) && (cyc >= q[0].due);
        ir_exp = !rst && !flush && ((q.size() == 0) || (ov_exp && bus.out_ready));
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, ir_exp});
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, ov_exp});
        chk("busy", {63'd0, busy}, {63'd0, q.size() != 0});
        if (ov_exp) begin
            chk("out_result", bus.out_result, q[0].res);
        end else if (q.size() != 0 && cyc > q[0].acc) begin
            chk("alu_src1", alu_src1, q[0].s1);
            chk("alu_src2", alu_src2, q[0].s2);
            chk("alu_func", {60'd0, alu_func}, {60'd0, q[0].f});
            chk("alu_inner", {60'd0, alu_inner}, {60'd0, q[0].inn});
        end
        if (rst || flush) begin
            q.delete();
        end else begin
            if (ov_exp && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && ir_exp) begin
                it.s1  = bus.in_src1;
                it.s2  = bus.in_src2;
                it.f   = bus.in_func;
                it.inn = bus.in_inner;
                it.res = alu_fn(bus.in_func, bus.in_inner, bus.in_src1, bus.in_src2);
                it.acc = cyc;
                it.due = cyc + 1 + exp_lat(bus.in_func, bus.in_src2);
                q.push_back(it);
            end
        end
    end

    int send_timeouts = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [3:0] f, input logic [3:0] inn,
                        input logic [63:0] a, input logic [63:0] b);
        bit acc;
        int n;
        bus.in_valid = 1'b1;
        bus.in_func  = f;
        bus.in_inner = inn;
        bus.in_src1  = a;
        bus.in_src2  = b;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) send_timeouts++;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) send_timeouts++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end

    initial begin
        logic [3:0]  f;
        logic [63:0] a, b;
        int          n;
        rst          = 1'b1;
        flush        = 1'b0;
        rdy_dir      = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_func  = '0;
        bus.in_inner = '0;
        bus.in_src1  = '0;
        bus.in_src2  = '0;
        tick(2);
        rst = 1'b0;

        send(4'd0, 4'd0, 64'd5, 64'd7);          bus.in_valid = 1'b0; tick(4);
        send(4'd5, 4'd0, 64'd3, 64'd4);          bus.in_valid = 1'b0; tick(8);

        rdy_dir = 1'b0;
        send(4'd3, 4'd0, 64'd100, 64'd7);        bus.in_valid = 1'b0;
        wait_valid();
        tick(10);
        rdy_dir = 1'b1;
        tick(3);

        send(4'd7, 4'd0, 64'd0, 64'h1000);
        send(4'd0, 4'd0, 64'd1, 64'd1);          bus.in_valid = 1'b0; tick(6);

        send(4'd3, 4'd0, 64'd50, 64'd5);         bus.in_valid = 1'b0; tick(2);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_func  = 4'd0;
        bus.in_src1  = 64'd9;
        bus.in_src2  = 64'd9;
        tick(1);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        tick(2);
        send(4'd0, 4'd0, 64'd2, 64'd2);          bus.in_valid = 1'b0; tick(4);

        send(4'd3, 4'd0, 64'd9, 64'd0);          bus.in_valid = 1'b0; tick(12);

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0 || i == 150) begin
                bus.in_valid = 1'b0;
                if (i == 150) rst = 1'b1; else flush = 1'b1;
                tick(1);
                rst   = 1'b0;
                flush = 1'b0;
            end
            f = 4'($urandom_range(0, 15));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 3));
            send(f, 4'($urandom_range(0, 15)), a, b);
            if ($urandom_range(0, 1) == 0) begin
                bus.in_valid = 1'b0;
                tick($urandom_range(0, 3));
            end
        end
        bus.in_valid = 1'b0;
        rand_rdy     = 1'b0;
        rdy_dir      = 1'b1;

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tick(2);
        chk("drain", 64'(q.size()), 64'd0);
        chk("handshake_timeouts", 64'(send_timeouts), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
